coil_scheduler: RTL and testbench
=================================

COIL_SCHEDULER -- requirements
Module: coil_scheduler

Interface
REQ-001 SHALL have parameter CH, default 2, number of coil channels.
REQ-002 SHALL have parameter AW, default 24, angle width in bits.
REQ-003 SHALL have parameter MAXACR, default 3839, last angle count before wrap to 0.
REQ-004 SHALL have parameter TW, default 16, dwell-timeout counter width.
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have port tick  in  1  one-cycle angle step strobe.
REQ-008 SHALL have port run  in  1  0 = unsynchronised: counters preload, coils off.
REQ-009 SHALL have port phase  in  CH*AW  per-channel preload angle, channel i at bits [i*AW +: AW].
REQ-010 SHALL have port charge_angle  in  AW  pending charge-start angle.
REQ-011 SHALL have port ignition_angle  in  AW  pending ignition (charge-end) angle.
REQ-012 SHALL have port upd  in  1  loads charge/ignition into pending registers.
REQ-013 SHALL have port max_dwell  in  TW  dwell limit in clk cycles (macro only).
REQ-014 SHALL have port coil_out  out  CH  registered coil drive, 1 = charging.
REQ-015 SHALL have port acnt  out  CH*AW  per-channel angle counters.
REQ-016 SHALL have port cfg_err  out  1  sticky: active window with charge >= ignition.
REQ-017 SHALL have port dwell_trip  out  CH  sticky per-channel timeout flags (macro only, else 0).

Function
REQ-018 Counter i SHALL load phase[i] every cycle run=0; when run=1 and tick=1, SHALL go to 0 if equal to MAXACR, else increment.
REQ-019 Pending registers SHALL load on upd=1, independent of run/tick.
REQ-020 Each channel SHALL hold active charge/ignition copies, loaded from pending when that channel's counter wraps MAXACR->0 (tick cycle) and when run=0.
REQ-021 Per-channel FSM states: IDLE, CHARGE, DONE; coil_out[i]=1 only in CHARGE.
REQ-022 IDLE->CHARGE on tick when next count >= active charge and < active ignition, and charge < ignition.
REQ-023 CHARGE->DONE on tick when next count >= active ignition, or on wrap.
REQ-024 DONE->IDLE on wrap; DONE SHALL prevent re-charge within the same revolution.
REQ-025 coil_out SHALL change in the clk cycle after the qualifying tick (latency 1).
REQ-026 Active charge >= ignition at wrap load SHALL hold the channel in IDLE for that revolution and set cfg_err.
REQ-027 run=0 at any time SHALL force all channels to IDLE and coil_out to 0 on the next edge.
REQ-028 upd coincident with wrap SHALL deliver the new upd values to the active copy, not the old.
REQ-029 Channels SHALL be fully independent; simultaneous transitions on all channels allowed.

Reset
REQ-030 rst SHALL asynchronously clear counters, pending/active registers, FSMs to IDLE, coil_out, cfg_err, dwell_trip to 0.

Configuration
REQ-031 Macro COIL_SCHEDULER_DWELL_LIMIT_EN defined: per-channel TW-bit counter counts cycles in CHARGE; reaching max_dwell SHALL force CHARGE->DONE and set dwell_trip[i]; max_dwell=0 disables limit.
REQ-032 Macro undefined: no timeout logic, max_dwell ignored, dwell_trip tied 0.

Structure
REQ-033 FSM state enum and default widths SHALL live in shared package coil_sched_pkg.
REQ-034 One sub-module coil_channel (counter, active copies, FSM, timeout) SHALL be instantiated CH times via generate.

Verification
REQ-035 run=0, phase={832,2752}, run=1, 10 ticks -> acnt={842,2762}; counter at 3839 + tick -> 0.
REQ-036 charge=100, ignition=200, upd, ch0 from 0 -> coil_out[0] rises one clk after tick reaching 100, falls one clk after tick reaching 200.
REQ-037 charge=300, ignition=200 at wrap -> coil_out stays 0 whole revolution, cfg_err=1 until rst.
REQ-038 run dropped while coil_out[0]=1 -> coil_out=0 next edge, acnt=phase.
REQ-039 upd (charge=500) in same cycle as ch0 wrap -> ch0 charges at 500 this revolution.
REQ-040 Macro on, max_dwell=20, window 100..200 with tick every 4 clk -> coil_out[0] high exactly 20 clk, dwell_trip[0]=1.

Source files
------------

// File: rtl/coil_sched_pkg.sv
// coil_sched_pkg: shared channel state encoding and default widths for the coil scheduler.
package coil_sched_pkg;
    typedef enum logic [1:0] {IDLE, CHARGE, DONE} coil_st_e;
    localparam int DEF_CH     = 2;
    localparam int DEF_AW     = 24;
    localparam int DEF_MAXACR = 3839;
    localparam int DEF_TW     = 16;
endpackage

// File: rtl/coil_channel.sv
// coil_channel: one coil's angle counter, active window copies and charge FSM.
// COIL_SCHEDULER_DWELL_LIMIT_EN adds a dwell timeout that forces CHARGE->DONE.
module coil_channel
    import coil_sched_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int MAXACR = DEF_MAXACR,
    parameter int TW     = DEF_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          run,
    input  logic [AW-1:0] phase_i,
    input  logic [AW-1:0] chg_i,
    input  logic [AW-1:0] ign_i,
    input  logic [TW-1:0] max_dwell_i,
    output logic          coil_o,
    output logic [AW-1:0] acnt_o,
    output logic          err_o,
    output logic          trip_o
);
    logic [AW-1:0] cnt_q, cnt_d, chg_q, chg_d, ign_q, ign_d, nxt, cmp_chg, cmp_ign;
    logic          err_q, err_d, step, wrap, load, in_win, tmo;
    coil_st_e      st_q, st_d;

    assign step    = run && tick;
    assign wrap    = cnt_q == AW'(MAXACR);
    assign nxt     = wrap ? '0 : cnt_q + 1'b1;
    assign load    = !run || (step && wrap);
    // On the wrap tick the window being entered is the freshly loaded one
    assign cmp_chg = wrap ? chg_i : chg_q;
    assign cmp_ign = wrap ? ign_i : ign_q;
    assign in_win  = nxt >= cmp_chg && nxt < cmp_ign;

    always_comb begin
        cnt_d = !run ? phase_i : step ? nxt : cnt_q;
        chg_d = load ? chg_i : chg_q;
        ign_d = load ? ign_i : ign_q;
        err_d = err_q || (step && wrap && chg_i >= ign_i);
        st_d  = st_q;
        if (!run)
            st_d = IDLE;
        else if (tmo)
            st_d = DONE;
        else if (step)
            case (st_q)
                IDLE:    st_d = in_win ? CHARGE : IDLE;
                CHARGE:  st_d = (wrap || nxt >= cmp_ign) ? DONE : CHARGE;
                DONE:    st_d = wrap ? IDLE : DONE;
                default: st_d = IDLE;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            chg_q <= '0;
            ign_q <= '0;
            err_q <= 1'b0;
            st_q  <= IDLE;
        end else begin
            cnt_q <= cnt_d;
            chg_q <= chg_d;
            ign_q <= ign_d;
            err_q <= err_d;
            st_q  <= st_d;
        end
    end

`ifdef COIL_SCHEDULER_DWELL_LIMIT_EN
    logic [TW-1:0] dw_q, dw_d;
    logic          trip_q, trip_d;

    assign dw_d   = st_q == CHARGE ? dw_q + 1'b1 : '0;
    assign tmo    = st_q == CHARGE && max_dwell_i != '0 && dw_d == max_dwell_i;
    assign trip_d = trip_q || (run && tmo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dw_q   <= '0;
            trip_q <= 1'b0;
        end else begin
            dw_q   <= dw_d;
            trip_q <= trip_d;
        end
    end

    assign trip_o = trip_q;
`else
    logic unused_dwell;
    assign unused_dwell = ^max_dwell_i;
    assign tmo          = 1'b0;
    assign trip_o       = 1'b0;
`endif

    assign coil_o = st_q == CHARGE;
    assign acnt_o = cnt_q;
    assign err_o  = err_q;
endmodule

// File: rtl/coil_scheduler.sv
// coil_scheduler: pending window registers feeding CH independent coil channels.
// COIL_SCHEDULER_DWELL_LIMIT_EN enables per-channel dwell timeout and dwell_trip.
module coil_scheduler
    import coil_sched_pkg::*;
#(
    parameter int CH     = DEF_CH,
    parameter int AW     = DEF_AW,
    parameter int MAXACR = DEF_MAXACR,
    parameter int TW     = DEF_TW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run,
    input  logic [CH*AW-1:0] phase,
    input  logic [AW-1:0]    charge_angle,
    input  logic [AW-1:0]    ignition_angle,
    input  logic             upd,
    input  logic [TW-1:0]    max_dwell,
    output logic [CH-1:0]    coil_out,
    output logic [CH*AW-1:0] acnt,
    output logic             cfg_err,
    output logic [CH-1:0]    dwell_trip
);
    logic [AW-1:0] chg_q, chg_d, ign_q, ign_d;
    logic [CH-1:0] err;

    // Channels take the next-state value so an upd coincident with a wrap lands immediately
    assign chg_d = upd ? charge_angle : chg_q;
    assign ign_d = upd ? ignition_angle : ign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_q <= '0;
            ign_q <= '0;
        end else begin
            chg_q <= chg_d;
            ign_q <= ign_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        coil_channel #(.AW(AW), .MAXACR(MAXACR), .TW(TW)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .run        (run),
            .phase_i    (phase[i*AW +: AW]),
            .chg_i      (chg_d),
            .ign_i      (ign_d),
            .max_dwell_i(max_dwell),
            .coil_o     (coil_out[i]),
            .acnt_o     (acnt[i*AW +: AW]),
            .err_o      (err[i]),
            .trip_o     (dwell_trip[i])
        );
    end

    assign cfg_err = |err;
endmodule

// File: tb/tb_coil_scheduler.sv
// tb_coil_scheduler: directed scoreboard bench for coil_scheduler (2 channels, 24-bit angles).
module tb_coil_scheduler;
    localparam int CH = 2, AW = 24, TW = 16;

    logic             clk = 1'b0, rst = 1'b1, tick = 1'b0, run = 1'b0, upd = 1'b0;
    logic [CH*AW-1:0] phase = '0;
    logic [AW-1:0]    charge_angle = '0, ignition_angle = '0;
    logic [TW-1:0]    max_dwell = '0;
    logic [CH-1:0]    coil_out, dwell_trip;
    logic [CH*AW-1:0] acnt;
    logic             cfg_err;

    coil_scheduler #(.CH(CH), .AW(AW), .MAXACR(3839), .TW(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .run           (run),
        .phase         (phase),
        .charge_angle  (charge_angle),
        .ignition_angle(ignition_angle),
        .upd           (upd),
        .max_dwell     (max_dwell),
        .coil_out      (coil_out),
        .acnt          (acnt),
        .cfg_err       (cfg_err),
        .dwell_trip    (dwell_trip)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;

    task automatic expect_v(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    initial begin
        int  hi;
        logic seen;
        cyc();
        cyc();
        expect_v("rst_coil", 0);   check(64'(coil_out));
        expect_v("rst_acnt", 0);   check(64'(acnt));
        expect_v("rst_cfg_err", 0); check(64'(cfg_err));
        expect_v("rst_trip", 0);   check(64'(dwell_trip));
        rst = 1'b0;

        // Preload and count
        charge_angle = 24'd100; ignition_angle = 24'd200; upd = 1'b1;
        phase = {24'd2752, 24'd832};
        cyc();
        upd = 1'b0;
        expect_v("preload_acnt", {24'd2752, 24'd832}); check(64'(acnt));
        run = 1'b1;
        ticks(10);
        expect_v("count10_acnt", {24'd2762, 24'd842}); check(64'(acnt));

        // Wrap at MAXACR
        run = 1'b0; phase = {24'd3838, 24'd3839};
        cyc();
        run = 1'b1;
        ticks(1);
        expect_v("wrap_ch0", {24'd3839, 24'd0}); check(64'(acnt));
        ticks(1);
        expect_v("wrap_ch1", {24'd0, 24'd1}); check(64'(acnt));
        expect_v("wrap_cfg_ok", 0); check(64'(cfg_err));

        // Charge window 100..200 on both channels together
        run = 1'b0; phase = '0;
        cyc();
        run = 1'b1;
        ticks(99);
        expect_v("win_pre_acnt", 99); check(64'(acnt[AW-1:0]));
        expect_v("win_pre_coil", 0);  check(64'(coil_out));
        ticks(1);
        expect_v("win_rise", 2'b11); check(64'(coil_out));
        ticks(99);
        expect_v("win_hold", 2'b11); check(64'(coil_out));
        ticks(1);
        expect_v("win_fall", 0); check(64'(coil_out));

        // Dropping run while charging
        run = 1'b0; cyc(); run = 1'b1;
        ticks(150);
        expect_v("drop_pre_coil", 2'b11); check(64'(coil_out));
        run = 1'b0; phase = {24'd7, 24'd5};
        cyc();
        expect_v("drop_coil", 0); check(64'(coil_out));
        expect_v("drop_acnt", {24'd7, 24'd5}); check(64'(acnt));

        // upd coincident with wrap takes effect this revolution
        phase = {24'd1000, 24'd3800};
        cyc();
        run = 1'b1;
        ticks(39);
        expect_v("updw_pre_acnt", 3839); check(64'(acnt[AW-1:0]));
        charge_angle = 24'd500; ignition_angle = 24'd600; upd = 1'b1; tick = 1'b1;
        cyc();
        upd = 1'b0; tick = 1'b0;
        expect_v("updw_wrap_acnt", 0); check(64'(acnt[AW-1:0]));
        ticks(100);
        expect_v("updw_old_window", 0); check(64'(coil_out));
        ticks(400);
        expect_v("updw_new_window", 2'b01); check(64'(coil_out));

        // Inverted window loaded at wrap
        charge_angle = 24'd300; ignition_angle = 24'd200; upd = 1'b1;
        cyc();
        upd = 1'b0; run = 1'b0; phase = {24'd3839, 24'd3839};
        cyc();
        run = 1'b1;
        ticks(1);
        expect_v("bad_cfg_err", 1); check(64'(cfg_err));
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            ticks(1);
            seen = seen | (|coil_out);
        end
        expect_v("bad_cfg_coil", 0); check(64'(seen));
        run = 1'b0; cyc(); cyc();
        expect_v("bad_cfg_sticky", 1); check(64'(cfg_err));
        rst = 1'b1; cyc(); rst = 1'b0;
        expect_v("bad_cfg_rst", 0); check(64'(cfg_err));

        // Dwell limit with a tick every 4 clocks
        charge_angle = 24'd100; ignition_angle = 24'd200; upd = 1'b1; max_dwell = 16'd20;
        phase = {24'd50, 24'd0};
        cyc();
        upd = 1'b0; run = 1'b1;
        hi = 0;
        for (int k = 0; k < 210; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            hi += int'(coil_out[0]);
            for (int j = 0; j < 3; j++) begin
                cyc();
                hi += int'(coil_out[0]);
            end
        end
`ifdef COIL_SCHEDULER_DWELL_LIMIT_EN
        expect_v("dwell_high_clks", 20);   check(64'(hi));
        expect_v("dwell_trip", 2'b11);     check(64'(dwell_trip));
`else
        expect_v("dwell_high_clks", 400);  check(64'(hi));
        expect_v("dwell_trip", 0);         check(64'(dwell_trip));
`endif
        expect_v("dwell_end_acnt", 210); check(64'(acnt[AW-1:0]));

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
